// File: rtl/fir_mac_seq_if.sv
// -----------------------------------------------------------------------------
// fir_mac_seq_if
// Handshake and coefficient-bus bundle for the time-multiplexed FIR filter.
//
// Signals
//   in_valid / in_ready / data_i     sample input handshake (WIDTH-bit signed)
//   out_valid / out_ready / data_o   filtered output handshake (WIDTH-bit signed)
//   sat_o                            clip flag, present only with FIR_SAT_EN
//   coef_we / coef_addr / coef_data  coefficient write port
//   coef_ready                       coefficient writes accepted this cycle
//
// Modports
//   master : the surrounding datapath (drives samples, coefficients, out_ready)
//   slave  : the filter itself
//
// Build option: define FIR_SAT_EN to add the sat_o clip flag.
// -----------------------------------------------------------------------------
interface fir_mac_seq_if #(
    parameter int WIDTH  = 16,
    parameter int CWIDTH = 16,
    parameter int TAPS   = 17
);
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  data_i;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  data_o;
`ifdef FIR_SAT_EN
    logic              sat_o;
`endif
    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [CWIDTH-1:0] coef_data;
    logic              coef_ready;

`ifdef FIR_SAT_EN
    modport master (
        output in_valid, data_i, out_ready, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, data_o, sat_o, coef_ready
    );
    modport slave (
        input  in_valid, data_i, out_ready, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, data_o, sat_o, coef_ready
    );
`else
    modport master (
        output in_valid, data_i, out_ready, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, data_o, coef_ready
    );
    modport slave (
        input  in_valid, data_i, out_ready, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, data_o, coef_ready
    );
`endif
endinterface

// File: rtl/fir_mac_seq.sv
// -----------------------------------------------------------------------------
// fir_mac_seq
// Time-multiplexed FIR low-pass for the FM demodulator baseband path. A single
// multiply-accumulate unit is iterated over TAPS coefficients held in a
// runtime-loadable bank; samples live in a circular delay line.
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   clr_i  in   synchronous flush: zero delay line/pointer/acc, abort, go IDLE
//   bus    slave modport of fir_mac_seq_if (sample in/out handshakes,
//              coefficient write port, optional sat_o)
//
// Operation: IDLE accepts one sample, MAC runs TAPS cycles (cycle k adds
// coef[k]*x[n-k]), OUT registers the rounded result and holds it until the
// consumer takes it. A sample accepted at edge 0 is presented after edge
// TAPS+1.
//
// Build option: FIR_SAT_EN -- saturate data_o to the WIDTH-bit range and
// flag clipping on sat_o; otherwise data_o wraps.
// -----------------------------------------------------------------------------
module fir_mac_seq #(
    parameter int WIDTH  = 16,
    parameter int CWIDTH = 16,
    parameter int TAPS   = 17,
    parameter int FRAC   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    fir_mac_seq_if.slave  bus
);
    localparam int AW   = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PW   = WIDTH + CWIDTH;      // full product width
    localparam int ACCW = PW + AW;             // accumulator cannot overflow
    localparam int RW   = ACCW + 1 - FRAC;     // width of the rounded result

    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);
    localparam logic [ACCW:0] HALF     = (ACCW+1)'(1) << (FRAC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Round half-up then drop FRAC fraction bits with an arithmetic shift.
    // One guard bit keeps the +HALF from overflowing near full scale.
    function automatic logic signed [RW-1:0] round_acc(input logic signed [ACCW-1:0] a);
        logic signed [ACCW:0] t;
        t = {a[ACCW-1], a} + HALF;
        return RW'(t >>> FRAC);
    endfunction

`ifdef FIR_SAT_EN
    // Returns {clipped, value}. The value fits when all bits from the output
    // sign bit upward agree; otherwise clip towards the sign of r.
    function automatic logic [WIDTH:0] saturate(input logic signed [RW-1:0] r);
        logic hi_ones;
        logic hi_zeros;
        hi_ones  = &r[RW-1:WIDTH-1];
        hi_zeros = ~|r[RW-1:WIDTH-1];
        if (hi_ones || hi_zeros) begin
            return {1'b0, r[WIDTH-1:0]};
        end else if (r[RW-1]) begin
            return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
        end
    endfunction
`endif

    state_t              state_r;
    state_t              state_s;

    logic [WIDTH-1:0]    dline_r [TAPS];
    logic [CWIDTH-1:0]   coef_r  [TAPS];
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [AW-1:0]       k_r;
    logic signed [ACCW-1:0] acc_r;

    logic                in_ready_r;
    logic                coef_ready_r;
    logic                out_valid_r;
    logic [WIDTH-1:0]    data_o_r;

    logic                accept_s;
    logic                mac_en_s;
    logic                load_out_s;
    logic                out_done_s;
    logic                coef_wr_s;
    logic                in_ready_s;
    logic                coef_ready_s;

    logic signed [PW-1:0] x_ext_s;
    logic signed [PW-1:0] c_ext_s;
    logic signed [PW-1:0] prod_s;
    logic [WIDTH-1:0]     out_data_s;

`ifdef FIR_SAT_EN
    logic                 out_sat_s;
    logic                 sat_r;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; clr_i overrides every transition.
    always_comb begin
        state_s = state_r;
        if (clr_i) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        state_s = ST_MAC;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_MAC: begin
                    if (k_r == LAST_IDX) begin
                        state_s = ST_OUT;
                    end else begin
                        state_s = ST_MAC;
                    end
                end
                ST_OUT: begin
                    if (out_valid_r && bus.out_ready) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_OUT;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: datapath strobes and the next values of the ready flags.
    // OUT spends its first cycle loading data_o, then holds until taken.
    always_comb begin
        accept_s   = 1'b0;
        mac_en_s   = 1'b0;
        load_out_s = 1'b0;
        out_done_s = 1'b0;
        if (clr_i) begin
            accept_s   = 1'b0;
            mac_en_s   = 1'b0;
            load_out_s = 1'b0;
            out_done_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: accept_s = bus.in_valid & in_ready_r;
                ST_MAC:  mac_en_s = 1'b1;
                ST_OUT: begin
                    load_out_s = ~out_valid_r;
                    out_done_s = out_valid_r & bus.out_ready;
                end
                default: begin
                    accept_s   = 1'b0;
                    mac_en_s   = 1'b0;
                    load_out_s = 1'b0;
                    out_done_s = 1'b0;
                end
            endcase
        end
        in_ready_s   = (state_s == ST_IDLE);
        coef_ready_s = (state_s != ST_MAC);
        coef_wr_s    = bus.coef_we & coef_ready_r & (bus.coef_addr <= LAST_IDX);
    end

    // Sign-extended operands and the single shared multiplier.
    always_comb begin
        x_ext_s = {{CWIDTH{dline_r[rd_ptr_r][WIDTH-1]}}, dline_r[rd_ptr_r]};
        c_ext_s = {{WIDTH{coef_r[k_r][CWIDTH-1]}}, coef_r[k_r]};
        prod_s  = x_ext_s * c_ext_s;
    end

`ifdef FIR_SAT_EN
    assign {out_sat_s, out_data_s} = saturate(round_acc(acc_r));
`else
    assign out_data_s = WIDTH'(round_acc(acc_r));
`endif

    // Coefficient bank; clr_i deliberately leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                coef_r[i] <= {CWIDTH{1'b0}};
            end
        end else if (coef_wr_s) begin
            coef_r[bus.coef_addr] <= bus.coef_data;
        end
    end

    // Circular delay line: the newest sample overwrites the oldest slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                dline_r[i] <= {WIDTH{1'b0}};
            end
        end else if (clr_i) begin
            for (int i = 0; i < TAPS; i++) begin
                dline_r[i] <= {WIDTH{1'b0}};
            end
        end else if (accept_s) begin
            dline_r[wr_ptr_r] <= bus.data_i;
        end
    end

    // Pointers and tap counter. The read pointer starts on the slot just
    // written (x[n]) and walks backwards modulo TAPS, giving x[n-k] at tap k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            k_r      <= {AW{1'b0}};
        end else if (clr_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            k_r      <= {AW{1'b0}};
        end else if (accept_s) begin
            wr_ptr_r <= (wr_ptr_r == LAST_IDX) ? {AW{1'b0}} : wr_ptr_r + AW'(1);
            rd_ptr_r <= wr_ptr_r;
            k_r      <= {AW{1'b0}};
        end else if (mac_en_s) begin
            rd_ptr_r <= (rd_ptr_r == {AW{1'b0}}) ? LAST_IDX : rd_ptr_r - AW'(1);
            k_r      <= k_r + AW'(1);
        end
    end

    // Accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {ACCW{1'b0}};
        end else if (clr_i || accept_s) begin
            acc_r <= {ACCW{1'b0}};
        end else if (mac_en_s) begin
            acc_r <= acc_r + {{AW{prod_s[PW-1]}}, prod_s};
        end
    end

    // Registered ready flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r   <= 1'b0;
            coef_ready_r <= 1'b0;
        end else begin
            in_ready_r   <= in_ready_s;
            coef_ready_r <= coef_ready_s;
        end
    end

    // Output register: loaded once per result, held until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            data_o_r    <= {WIDTH{1'b0}};
        end else if (clr_i) begin
            out_valid_r <= 1'b0;
        end else if (load_out_s) begin
            out_valid_r <= 1'b1;
            data_o_r    <= out_data_s;
        end else if (out_done_s) begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef FIR_SAT_EN
    // Clip flag travels with the result it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_r <= 1'b0;
        end else if (clr_i) begin
            sat_r <= 1'b0;
        end else if (load_out_s) begin
            sat_r <= out_sat_s;
        end else if (out_done_s) begin
            sat_r <= 1'b0;
        end
    end

    assign bus.sat_o = sat_r;
`endif

    assign bus.in_ready   = in_ready_r;
    assign bus.coef_ready = coef_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.data_o     = data_o_r;

endmodule
